// File: rtl/wb_stage_mp.sv
// Multi-lane writeback stage: final pipeline stage after MEM.
// Holds one packet of NUM_LANES retiring instructions, drives one regfile
// write port per lane and exports per-lane bypass info to ID.
// Optional feature macro: WB_DEBUG_TRACE_EN. When defined, lanes retire one
// per cycle (oldest first) so the single-port debug trace stays in program
// order; when undefined, all lanes retire together and the trace is tied off.
module wb_stage_mp #(
    parameter int unsigned NUM_LANES = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_LANES*71-1:0]   to_WB_data,
    input  logic                      MEM_to_WB_valid,
    output logic                      WB_allow_in,
    output logic [NUM_LANES-1:0]      rf_we,
    output logic [5*NUM_LANES-1:0]    rf_waddr,
    output logic [32*NUM_LANES-1:0]   rf_wdata,
    output logic [NUM_LANES-1:0]      wb_fwd_valid,
    output logic [5*NUM_LANES-1:0]    wb_fwd_dest,
    output logic [32*NUM_LANES-1:0]   wb_fwd_data,
    output logic [31:0]               debug_wb_pc,
    output logic [3:0]                debug_wb_rf_we,
    output logic [4:0]                debug_wb_rf_wnum,
    output logic [31:0]               debug_wb_rf_wdata
);

    localparam int unsigned LANE_W = 71;
    localparam int unsigned PKT_W  = NUM_LANES * LANE_W;

    // Lane field offsets inside a 71-bit lane: {lane_v, pc, dest, result, gr_we}
    localparam int unsigned OFS_WE   = 0;
    localparam int unsigned OFS_RES  = 1;
    localparam int unsigned OFS_DEST = 33;
    localparam int unsigned OFS_PC   = 38;
    localparam int unsigned OFS_V    = 70;

    logic                      wb_valid_q;
    logic [PKT_W-1:0]          payload_q;
    logic [NUM_LANES-1:0]      pend_q;

    logic [NUM_LANES-1:0]      lane_v;
    logic [NUM_LANES-1:0]      lane_gr_we;
    logic [NUM_LANES-1:0]      lane_v_in;
    logic [5*NUM_LANES-1:0]    dest_flat;
    logic [32*NUM_LANES-1:0]   res_flat;
    logic [32*NUM_LANES-1:0]   pc_flat;

    logic [NUM_LANES-1:0]      w;
    logic [NUM_LANES-1:0]      sel;
    logic                      wb_ready_go;

    // Keep only the youngest candidate among lanes sharing a destination register
    function automatic logic [NUM_LANES-1:0] youngest_wins(
        input logic [NUM_LANES-1:0]   cand,
        input logic [5*NUM_LANES-1:0] dests
    );
        logic [NUM_LANES-1:0] keep;
        keep = cand;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            for (int j = i + 1; j < int'(NUM_LANES); j++) begin
                if (cand[j] && (dests[j*5 +: 5] == dests[i*5 +: 5])) begin
                    keep[i] = 1'b0;
                end
            end
        end
        return keep;
    endfunction

    // Unpack lane fields from the held payload and the incoming packet
    for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane
        localparam int unsigned BASE = g * LANE_W;
        assign lane_v[g]           = payload_q[BASE + OFS_V];
        assign lane_gr_we[g]       = payload_q[BASE + OFS_WE];
        assign dest_flat[g*5 +: 5] = payload_q[BASE + OFS_DEST +: 5];
        assign res_flat[g*32 +: 32] = payload_q[BASE + OFS_RES +: 32];
        assign pc_flat[g*32 +: 32]  = payload_q[BASE + OFS_PC +: 32];
        assign lane_v_in[g]        = to_WB_data[BASE + OFS_V];
        assign w[g] = wb_valid_q & lane_v[g] & lane_gr_we[g] & (dest_flat[g*5 +: 5] != 5'd0);
    end

    // Oldest still-pending lane (one-hot lowest set bit of pend)
    always_comb begin
        sel = '0;
        for (int i = int'(NUM_LANES) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel = '0;
                sel[i] = 1'b1;
            end
        end
    end

`ifdef WB_DEBUG_TRACE_EN
    // Stall until at most one lane remains pending
    assign wb_ready_go = ((pend_q & (pend_q - NUM_LANES'(1))) == '0);
`else
    assign wb_ready_go = 1'b1;

    logic unused_trace_pc;
    assign unused_trace_pc = ^pc_flat;
`endif

    assign WB_allow_in = ~wb_valid_q | wb_ready_go;

    // Packet register and per-lane pending mask
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid_q <= 1'b0;
            payload_q  <= '0;
            pend_q     <= '0;
        end else if (WB_allow_in) begin
            wb_valid_q <= MEM_to_WB_valid;
            payload_q  <= to_WB_data;
            pend_q     <= MEM_to_WB_valid ? lane_v_in : '0;
        end else begin
            pend_q     <= pend_q & ~sel;
        end
    end

    // Regfile write ports, bypass info and debug trace
    always_comb begin
        rf_we             = '0;
        rf_waddr          = '0;
        rf_wdata          = '0;
        wb_fwd_valid      = '0;
        wb_fwd_dest       = '0;
        wb_fwd_data       = '0;
        debug_wb_pc       = '0;
        debug_wb_rf_we    = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;

        if (wb_valid_q) begin
            rf_waddr     = dest_flat;
            rf_wdata     = res_flat;
            wb_fwd_dest  = dest_flat;
            wb_fwd_data  = res_flat;
            wb_fwd_valid = youngest_wins(w & pend_q, dest_flat);
`ifdef WB_DEBUG_TRACE_EN
            rf_we          = sel & w;
            debug_wb_rf_we = {4{|(sel & w)}};
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (sel[i]) begin
                    debug_wb_pc       = pc_flat[i*32 +: 32];
                    debug_wb_rf_wnum  = dest_flat[i*5 +: 5];
                    debug_wb_rf_wdata = res_flat[i*32 +: 32];
                end
            end
`else
            rf_we = youngest_wins(w, dest_flat);
`endif
        end
    end

endmodule
